// File: rtl/otter_pkg.sv
// Shared encodings for the OTTER multicycle control unit: opcodes, ALU function
// codes, FSM state codes and datapath mux select values.
package otter_pkg;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SUB  = 4'd8,
        ALU_LUI  = 4'd9,
        ALU_SRA  = 4'd13
    } alu_fun_t;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;
    localparam logic [1:0] ST_INTR  = 2'd3;

    localparam logic [2:0] PC_SEL_PC4    = 3'd0;
    localparam logic [2:0] PC_SEL_JALR   = 3'd1;
    localparam logic [2:0] PC_SEL_BRANCH = 3'd2;
    localparam logic [2:0] PC_SEL_JAL    = 3'd3;
    localparam logic [2:0] PC_SEL_MTVEC  = 3'd4;
    localparam logic [2:0] PC_SEL_MEPC   = 3'd5;

    localparam logic [1:0] RF_SEL_PC4 = 2'd0;
    localparam logic [1:0] RF_SEL_CSR = 2'd1;
    localparam logic [1:0] RF_SEL_MEM = 2'd2;
    localparam logic [1:0] RF_SEL_ALU = 2'd3;

    localparam logic [1:0] SRCA_RS1     = 2'd0;
    localparam logic [1:0] SRCA_UIMM    = 2'd1;
    localparam logic [1:0] SRCA_NOT_RS1 = 2'd2;

    localparam logic [2:0] SRCB_RS2  = 3'd0;
    localparam logic [2:0] SRCB_IIMM = 3'd1;
    localparam logic [2:0] SRCB_SIMM = 3'd2;
    localparam logic [2:0] SRCB_PC   = 3'd3;
    localparam logic [2:0] SRCB_CSR  = 3'd4;

    localparam logic [31:0] MRET_INSTR = 32'h30200073;

    // funct3 010/011 are not valid branch conditions and never take the branch.
    function automatic logic br_taken(input logic [2:0] f3, input logic eq,
                                      input logic lt, input logic ltu);
        logic t;
        case (f3)
            3'b000:  t = eq;
            3'b001:  t = !eq;
            3'b100:  t = lt;
            3'b101:  t = !lt;
            3'b110:  t = ltu;
            3'b111:  t = !ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/otter_ctrl_decoder.sv
// Combinational instruction decoder: IR + branch flags -> ALU op, mux selects and
// raw strobes. CSR/mret decode is present only with OTTER_INTR_EN defined.
module otter_ctrl_decoder
    import otter_pkg::*;
(
    input  logic [31:0] ir,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    output logic [3:0]  alu_fun,
    output logic [1:0]  srca_sel,
    output logic [2:0]  srcb_sel,
    output logic [2:0]  pc_sel,
    output logic [1:0]  rf_sel,
    output logic        rf_we,
    output logic        mem_rden2,
    output logic        mem_we2,
    output logic        csr_we,
    output logic        mret_exec,
    output logic        is_load
);

    logic [2:0] f3;
    assign f3 = ir[14:12];

    always_comb begin
        alu_fun   = ALU_ADD;
        srca_sel  = SRCA_RS1;
        srcb_sel  = SRCB_RS2;
        pc_sel    = PC_SEL_PC4;
        rf_sel    = RF_SEL_PC4;
        rf_we     = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        csr_we    = 1'b0;
        mret_exec = 1'b0;
        is_load   = 1'b0;
        case (ir[6:0])
            OPC_LUI: begin
                alu_fun  = ALU_LUI;
                srca_sel = SRCA_UIMM;
                rf_sel   = RF_SEL_ALU;
                rf_we    = 1'b1;
            end
            OPC_AUIPC: begin
                srca_sel = SRCA_UIMM;
                srcb_sel = SRCB_PC;
                rf_sel   = RF_SEL_ALU;
                rf_we    = 1'b1;
            end
            OPC_JAL: begin
                pc_sel = PC_SEL_JAL;
                rf_we  = 1'b1;
            end
            OPC_JALR: begin
                pc_sel = PC_SEL_JALR;
                rf_we  = 1'b1;
            end
            OPC_BRANCH: pc_sel = br_taken(f3, br_eq, br_lt, br_ltu) ? PC_SEL_BRANCH : PC_SEL_PC4;
            OPC_LOAD: begin
                srcb_sel  = SRCB_IIMM;
                mem_rden2 = 1'b1;
                is_load   = 1'b1;
            end
            OPC_STORE: begin
                srcb_sel = SRCB_SIMM;
                mem_we2  = 1'b1;
            end
            OPC_OP_IMM: begin
                // IR[30] only selects SRAI; for other immediates it is immediate data.
                alu_fun  = {ir[30] & (f3 == 3'b101), f3};
                srcb_sel = SRCB_IIMM;
                rf_sel   = RF_SEL_ALU;
                rf_we    = 1'b1;
            end
            OPC_OP: begin
                alu_fun = {ir[30], f3};
                rf_sel  = RF_SEL_ALU;
                rf_we   = 1'b1;
            end
`ifdef OTTER_INTR_EN
            OPC_SYSTEM: begin
                if (ir == MRET_INSTR) begin
                    pc_sel    = PC_SEL_MEPC;
                    mret_exec = 1'b1;
                end else if (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011) begin
                    csr_we = 1'b1;
                    rf_sel = RF_SEL_CSR;
                    rf_we  = 1'b1;
                    case (f3)
                        3'b001:  alu_fun = ALU_LUI;
                        3'b010: begin
                            alu_fun  = ALU_OR;
                            srcb_sel = SRCB_CSR;
                        end
                        default: begin
                            alu_fun  = ALU_AND;
                            srca_sel = SRCA_NOT_RS1;
                            srcb_sel = SRCB_CSR;
                        end
                    endcase
                end
            end
`endif
            default: ;
        endcase
    end

`ifndef OTTER_INTR_EN
    logic unused_ir;
    assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};
`endif

endmodule

// File: rtl/otter_ctrl_unit.sv
// OTTER multicycle control FSM (FETCH/EXEC/WB, plus INTR when OTTER_INTR_EN is
// defined); gates the decoder's strobes by state. Outputs are all 0 in reset.
module otter_ctrl_unit
    import otter_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IR,
    input  logic        BR_EQ,
    input  logic        BR_LT,
    input  logic        BR_LTU,
    input  logic        INTR,
    output logic        PC_WE,
    output logic [2:0]  PC_SEL,
    output logic        RF_WE,
    output logic [1:0]  RF_SEL,
    output logic        MEM_RDEN1,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [3:0]  ALU_FUN,
    output logic [1:0]  SRCA_SEL,
    output logic [2:0]  SRCB_SEL,
    output logic        CSR_WE,
    output logic        INT_TAKEN,
    output logic        MRET_EXEC
);

    logic [1:0] state_q, state_d;
    logic [3:0] dec_alu_fun;
    logic [1:0] dec_srca_sel, dec_rf_sel;
    logic [2:0] dec_srcb_sel, dec_pc_sel;
    logic       dec_rf_we, dec_mem_rden2, dec_mem_we2, dec_csr_we, dec_mret_exec, dec_is_load;
    logic       intr_go;

    otter_ctrl_decoder u_dec (
        .ir        (IR),
        .br_eq     (BR_EQ),
        .br_lt     (BR_LT),
        .br_ltu    (BR_LTU),
        .alu_fun   (dec_alu_fun),
        .srca_sel  (dec_srca_sel),
        .srcb_sel  (dec_srcb_sel),
        .pc_sel    (dec_pc_sel),
        .rf_sel    (dec_rf_sel),
        .rf_we     (dec_rf_we),
        .mem_rden2 (dec_mem_rden2),
        .mem_we2   (dec_mem_we2),
        .csr_we    (dec_csr_we),
        .mret_exec (dec_mret_exec),
        .is_load   (dec_is_load)
    );

`ifdef OTTER_INTR_EN
    assign intr_go = INTR;
`else
    logic unused_intr;
    assign intr_go     = 1'b0;
    assign unused_intr = INTR;
`endif

    // A load always completes its WB before an interrupt is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC:  state_d = dec_is_load ? ST_WB : (intr_go ? ST_INTR : ST_FETCH);
            ST_WB:    state_d = intr_go ? ST_INTR : ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        PC_WE     = 1'b0;
        PC_SEL    = PC_SEL_PC4;
        RF_WE     = 1'b0;
        RF_SEL    = RF_SEL_PC4;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        ALU_FUN   = ALU_ADD;
        SRCA_SEL  = SRCA_RS1;
        SRCB_SEL  = SRCB_RS2;
        CSR_WE    = 1'b0;
        INT_TAKEN = 1'b0;
        MRET_EXEC = 1'b0;
        if (RST_N) begin
            case (state_q)
                ST_FETCH: MEM_RDEN1 = 1'b1;
                ST_EXEC: begin
                    PC_WE     = !dec_is_load;
                    PC_SEL    = dec_pc_sel;
                    RF_WE     = dec_rf_we;
                    RF_SEL    = dec_rf_sel;
                    MEM_RDEN2 = dec_mem_rden2;
                    MEM_WE2   = dec_mem_we2;
                    ALU_FUN   = dec_alu_fun;
                    SRCA_SEL  = dec_srca_sel;
                    SRCB_SEL  = dec_srcb_sel;
                    CSR_WE    = dec_csr_we;
                    MRET_EXEC = dec_mret_exec;
                end
                ST_WB: begin
                    RF_SEL = RF_SEL_MEM;
                    RF_WE  = 1'b1;
                    PC_WE  = 1'b1;
                end
`ifdef OTTER_INTR_EN
                ST_INTR: begin
                    PC_SEL    = PC_SEL_MTVEC;
                    PC_WE     = 1'b1;
                    INT_TAKEN = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_ctrl_unit.sv
// Self-checking bench for otter_ctrl_unit: directed scenarios plus randomized
// instruction streams against a per-instruction phase/decode reference model.
module tb_otter_ctrl_unit;

`ifdef OTTER_INTR_EN
    localparam bit INTR_EN = 1'b1;
`else
    localparam bit INTR_EN = 1'b0;
`endif

    localparam int P_FETCH = 0, P_EXEC = 1, P_WB = 2, P_INTR = 3;

    localparam logic [31:0] I_SW   = 32'h00A52023;
    localparam logic [31:0] I_ADD  = 32'h00B50533;
    localparam logic [31:0] I_SUB  = 32'h40B50533;
    localparam logic [31:0] I_SRAI = 32'h40355513;
    localparam logic [31:0] I_SRLI = 32'h00355513;
    localparam logic [31:0] I_LW   = 32'h00052583;
    localparam logic [31:0] I_BLT  = 32'hFEB54EE3;
    localparam logic [31:0] I_B010 = 32'hFEB52EE3;
    localparam logic [31:0] I_MRET = 32'h30200073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ir = '0;
    logic        br_eq = 1'b0, br_lt = 1'b0, br_ltu = 1'b0, intr = 1'b0;
    logic        pc_we, rf_we, mem_rden1, mem_rden2, mem_we2, csr_we, int_taken, mret_exec;
    logic [2:0]  pc_sel, srcb_sel;
    logic [1:0]  rf_sel, srca_sel;
    logic [3:0]  alu_fun;
    logic [21:0] obs;

    int errors = 0;
    int checks = 0;
    int m_ph   = P_FETCH;

    always #5 clk = ~clk;

    otter_ctrl_unit dut (
        .CLK(clk), .RST_N(rst_n), .IR(ir), .BR_EQ(br_eq), .BR_LT(br_lt), .BR_LTU(br_ltu),
        .INTR(intr), .PC_WE(pc_we), .PC_SEL(pc_sel), .RF_WE(rf_we), .RF_SEL(rf_sel),
        .MEM_RDEN1(mem_rden1), .MEM_RDEN2(mem_rden2), .MEM_WE2(mem_we2), .ALU_FUN(alu_fun),
        .SRCA_SEL(srca_sel), .SRCB_SEL(srcb_sel), .CSR_WE(csr_we), .INT_TAKEN(int_taken),
        .MRET_EXEC(mret_exec)
    );

    assign obs = {pc_we, pc_sel, rf_we, rf_sel, mem_rden1, mem_rden2, mem_we2, alu_fun,
                  srca_sel, srcb_sel, csr_we, int_taken, mret_exec};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (ir=%h phase=%0d)", tag, got, exp, ir, m_ph);
        end
    endtask

    // Expected outputs for one cycle, read straight from the instruction rules.
    function automatic logic [21:0] model_out(input int ph, input logic [31:0] i,
                                              input logic eq, input logic lt,
                                              input logic ltu, input logic rn);
        logic       pcwe, rfwe, rd1, rd2, we2, cwe, it, mr, taken;
        logic [2:0] pcs, sb, f3;
        logic [1:0] rfs, sa;
        logic [3:0] alu;
        logic [7:0] base;
        {pcwe, rfwe, rd1, rd2, we2, cwe, it, mr} = '0;
        pcs = 0; sb = 0; rfs = 0; sa = 0; alu = 0;
        f3 = i[14:12];
        if (rn) begin
            if (ph == P_FETCH) rd1 = 1;
            else if (ph == P_WB) begin rfs = 2; rfwe = 1; pcwe = 1; end
            else if (ph == P_INTR) begin pcs = 4; pcwe = 1; it = 1; end
            else begin
                pcwe = 1;
                case (i[6:0])
                    7'h37: begin alu = 9; sa = 1; rfs = 3; rfwe = 1; end
                    7'h17: begin sa = 1; sb = 3; rfs = 3; rfwe = 1; end
                    7'h6F: begin pcs = 3; rfwe = 1; end
                    7'h67: begin pcs = 1; rfwe = 1; end
                    7'h63: begin
                        base  = {ltu, ltu, lt, lt, 1'b0, 1'b0, eq, eq};
                        taken = (f3 == 2 || f3 == 3) ? 1'b0 : (base[f3] ^ f3[0]);
                        pcs   = taken ? 3'd2 : 3'd0;
                    end
                    7'h03: begin pcwe = 0; rd2 = 1; sb = 1; end
                    7'h23: begin sb = 2; we2 = 1; end
                    7'h13: begin
                        alu = {1'b0, f3} + ((f3 == 5 && i[30]) ? 4'd8 : 4'd0);
                        sb = 1; rfs = 3; rfwe = 1;
                    end
                    7'h33: begin alu = {1'b0, f3} + (i[30] ? 4'd8 : 4'd0); rfs = 3; rfwe = 1; end
                    7'h73: begin
                        if (INTR_EN && i == I_MRET) begin pcs = 5; mr = 1; end
                        else if (INTR_EN && f3 >= 1 && f3 <= 3) begin
                            cwe = 1; rfs = 1; rfwe = 1;
                            sa  = (f3 == 3) ? 2'd2 : 2'd0;
                            sb  = (f3 == 1) ? 3'd0 : 3'd4;
                            alu = (f3 == 1) ? 4'd9 : ((f3 == 2) ? 4'd6 : 4'd7);
                        end
                    end
                    default: ;
                endcase
            end
        end
        return {pcwe, pcs, rfwe, rfs, rd1, rd2, we2, alu, sa, sb, cwe, it, mr};
    endfunction

    function automatic int next_ph(input int ph, input logic [31:0] i, input logic irq,
                                   input logic rn);
        if (!rn) return P_FETCH;
        case (ph)
            P_FETCH: return P_EXEC;
            P_EXEC:  return (i[6:0] == 7'h03) ? P_WB : ((INTR_EN && irq) ? P_INTR : P_FETCH);
            P_WB:    return (INTR_EN && irq) ? P_INTR : P_FETCH;
            default: return P_FETCH;
        endcase
    endfunction

    task automatic drv(input logic [31:0] i, input logic eq, input logic lt, input logic ltu,
                       input logic irq, input logic rn);
        @(negedge clk);
        ir = i; br_eq = eq; br_lt = lt; br_ltu = ltu; intr = irq; rst_n = rn;
        #1;
        chk("outs", 32'(obs), 32'(model_out(m_ph, i, eq, lt, ltu, rn)));
    endtask

    task automatic step();
        @(posedge clk);
        m_ph = next_ph(m_ph, ir, intr, rst_n);
    endtask

    task automatic run(input logic [31:0] i, input logic irq);
        drv(i, 1'($urandom), 1'($urandom), 1'($urandom), irq, 1'b1);
        step();
    endtask

    logic [6:0] opc_tbl [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h73, 7'h0F, 7'h7F};
    logic [31:0] rir;

    initial begin
        // reset
        drv(I_SW, 0, 0, 0, 0, 0);
        chk("rst_zero", 32'(obs), 32'd0);
        step();
        drv(I_SW, 0, 0, 0, 0, 0); step();
        drv(I_SW, 0, 0, 0, 0, 1);
        chk("rst_fetch_rden1", 32'(mem_rden1), 32'd1);
        step();
        // reset asserted mid-EXEC of a store
        drv(I_SW, 0, 0, 0, 0, 0);
        chk("t1_we2_rst_a", 32'(mem_we2), 32'd0);
        step();
        drv(I_SW, 0, 0, 0, 0, 0);
        chk("t1_we2_rst_b", 32'(mem_we2), 32'd0);
        step();
        drv(I_SW, 0, 0, 0, 0, 1);
        chk("t1_fetch_after_rst", 32'(mem_rden1), 32'd1);
        step();
        drv(I_SW, 0, 0, 0, 0, 1);
        chk("sw_exec_we2", 32'(mem_we2), 32'd1);
        step();
        // ADD / SUB
        run(I_ADD, 0);
        drv(I_ADD, 0, 0, 0, 0, 1);
        chk("add_alu", 32'(alu_fun), 32'd0);
        chk("add_rfwe", 32'(rf_we), 32'd1);
        chk("add_pcsel", 32'(pc_sel), 32'd0);
        step();
        run(I_SUB, 0);
        drv(I_SUB, 0, 0, 0, 0, 1);
        chk("sub_alu", 32'(alu_fun), 32'd8);
        step();
        // SRAI / SRLI
        run(I_SRAI, 0);
        drv(I_SRAI, 0, 0, 0, 0, 1);
        chk("srai_alu", 32'(alu_fun), 32'd13);
        chk("srai_srcb", 32'(srcb_sel), 32'd1);
        step();
        run(I_SRLI, 0);
        drv(I_SRLI, 0, 0, 0, 0, 1);
        chk("srli_alu", 32'(alu_fun), 32'd5);
        step();
        // LW: 3 cycles
        run(I_LW, 0);
        drv(I_LW, 0, 0, 0, 0, 1);
        chk("lw_exec_rden2", 32'(mem_rden2), 32'd1);
        chk("lw_exec_pcwe", 32'(pc_we), 32'd0);
        step();
        drv(I_LW, 0, 0, 0, 0, 1);
        chk("lw_wb_rfsel", 32'(rf_sel), 32'd2);
        chk("lw_wb_rfwe", 32'(rf_we), 32'd1);
        chk("lw_wb_pcwe", 32'(pc_we), 32'd1);
        step();
        drv(I_ADD, 0, 0, 0, 0, 1);
        chk("lw_then_fetch", 32'(mem_rden1), 32'd1);
        step();
        // branches
        drv(I_BLT, 0, 1, 0, 0, 1);
        chk("blt_taken", 32'(pc_sel), 32'd2);
        step();
        run(I_BLT, 0);
        drv(I_BLT, 1, 0, 1, 0, 1);
        chk("blt_not_taken", 32'(pc_sel), 32'd0);
        step();
        run(I_B010, 0);
        drv(I_B010, 1, 1, 1, 0, 1);
        chk("b010_never", 32'(pc_sel), 32'd0);
        step();
        // interrupt during a load
        run(I_LW, 1);
        drv(I_LW, 0, 0, 0, 1, 1);
        chk("lwi_exec_rden2", 32'(mem_rden2), 32'd1);
        step();
        drv(I_LW, 0, 0, 0, 1, 1);
        chk("lwi_wb_rfwe", 32'(rf_we), 32'd1);
        step();
`ifdef OTTER_INTR_EN
        drv(I_LW, 0, 0, 0, 1, 1);
        chk("intr_pcsel", 32'(pc_sel), 32'd4);
        chk("intr_taken", 32'(int_taken), 32'd1);
        step();
`endif
        drv(I_MRET, 0, 0, 0, 1, 1);
        chk("post_intr_fetch", 32'(mem_rden1), 32'd1);
        chk("post_intr_no_take", 32'(int_taken), 32'd0);
        step();
        drv(I_MRET, 0, 0, 0, 0, 1);
        chk("mret_pcsel", 32'(pc_sel), INTR_EN ? 32'd5 : 32'd0);
        chk("mret_exec", 32'(mret_exec), 32'(INTR_EN));
        step();
        // randomized instruction stream
        rir = I_ADD;
        for (int c = 0; c < 1500; c++) begin
            if (m_ph == P_FETCH) begin
                rir = $urandom;
                rir[6:0] = opc_tbl[$urandom_range(0, 11)];
                if ($urandom_range(0, 9) == 0) rir = I_MRET;
            end
            drv(rir, 1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) != 0));
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
